penc_rr: RTL and testbench

Parametrised, registered priority encoder with a valid/ready handshake on both sides. It converts an N-bit request vector into a binary index plus status flags: no bit set, more than one bit set, and population count. It keeps a saturating count of multi-hot inputs. It is the next generation of the team's one-hot encoders, for use where inputs are not guaranteed one-hot and the result feeds a pipelined datapath. An optional round-robin priority mode makes it usable as a fair arbiter front-end.

---
 rtl/penc_rr_if.sv | 30 +++
 rtl/penc_rr.sv | 125 ++++++++++++
 tb/tb_penc_rr.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/penc_rr_if.sv
// penc_rr_if: request/result handshake bundle for penc_rr.
// The slave modport is the encoder side; the master modport is the producer/consumer side.
interface penc_rr_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 16
);
  localparam int unsigned W = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_req;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_idx;
  logic          out_none;
  logic          out_multi;
  logic [W:0]    out_cnt;
  logic [CW-1:0] multi_cnt;
  logic          multi_clr;

  modport master (
    output in_valid, in_req, out_ready, multi_clr,
    input  in_ready, out_valid, out_idx, out_none, out_multi, out_cnt, multi_cnt
  );

  modport slave (
    input  in_valid, in_req, out_ready, multi_clr,
    output in_ready, out_valid, out_idx, out_none, out_multi, out_cnt, multi_cnt
  );
endinterface

// File: rtl/penc_rr.sv
// penc_rr: registered priority encoder with valid/ready on both sides.
// Reports winning index, none/multi flags, popcount, and a saturating
// count of accepted multi-hot vectors.
// Build option PENC_ROUND_ROBIN_EN: round-robin priority starting at a
// pointer that advances past each winner; otherwise lowest index wins.
module penc_rr #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 16
) (
  input logic      clk,
  input logic      rst_n,
  penc_rr_if.slave bus
);
  localparam int unsigned W = $clog2(N);

  logic          accept;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  idx_q, idx_d;
  logic          none_q, none_d;
  logic          multi_q, multi_d;
  logic [W:0]    cnt_q, cnt_d;
  logic [CW-1:0] mcnt_q, mcnt_d;
  logic [W-1:0]  idx_lo;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Lowest set bit over the whole vector (0 when the vector is empty)
  always_comb begin
    idx_lo = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (bus.in_req[i-1]) idx_lo = W'(i - 1);
    end
  end

`ifdef PENC_ROUND_ROBIN_EN
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_hi;
  logic         hit_hi;

  // Lowest set bit at or above ptr; if none, the search wraps to idx_lo
  always_comb begin
    idx_hi = '0;
    hit_hi = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (bus.in_req[i-1] && ((i - 1) >= 32'(ptr_q))) begin
        idx_hi = W'(i - 1);
        hit_hi = 1'b1;
      end
    end
  end

  assign idx_d = hit_hi ? idx_hi : idx_lo;

  // Pointer moves just past the winner; explicit wrap for non-power-of-two N
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !none_d) begin
      ptr_d = (idx_d == LAST) ? '0 : idx_d + W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign idx_d = idx_lo;
`endif

  // Popcount and status flags of the incoming vector
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d = cnt_d + (W+1)'(bus.in_req[i]);
    end
    none_d  = ~|bus.in_req;
    multi_d = (cnt_d > (W+1)'(1));
  end

  // Output-valid next state: load on accept, drain when consumed
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)             out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  // Saturating multi-hot counter; clear wins over increment
  always_comb begin
    mcnt_d = mcnt_q;
    if (bus.multi_clr)                            mcnt_d = '0;
    else if (accept && multi_d && (mcnt_q != '1)) mcnt_d = mcnt_q + CW'(1);
  end

  // State and result registers; data fields only change on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      none_q      <= 1'b0;
      multi_q     <= 1'b0;
      cnt_q       <= '0;
      mcnt_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      mcnt_q      <= mcnt_d;
      if (accept) begin
        idx_q   <= idx_d;
        none_q  <= none_d;
        multi_q <= multi_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_none  = none_q;
  assign bus.out_multi = multi_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.multi_cnt = mcnt_q;
endmodule

// File: tb/tb_penc_rr.sv
// tb_penc_rr: two encoders (N=8/CW=4 and N=5/CW=16) driven by shared
// stimulus; the N=5 instance sees the low five request bits.
module tb_penc_rr;
`ifdef PENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       multi_clr = 1'b0;
  logic [7:0] req = '0;

  always #5 clk = ~clk;

  penc_rr_if #(.N(8), .CW(4))  ia ();
  penc_rr_if #(.N(5), .CW(16)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.in_req    = req;
  assign ia.out_ready = out_ready;
  assign ia.multi_clr = multi_clr;
  assign ib.in_valid  = in_valid;
  assign ib.in_req    = req[4:0];
  assign ib.out_ready = out_ready;
  assign ib.multi_clr = multi_clr;

  penc_rr #(.N(8), .CW(4))  u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  penc_rr #(.N(5), .CW(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Behavioural model: one entry per instance
  int nsz[2]  = '{8, 5};
  int mmax[2] = '{15, 65535};
  int mv[2], midx[2], mnone[2], mmul[2], mpc[2], mm[2], mptr[2];

  // Scan positions p, p+1, ... modulo n; first requester wins
  function automatic int pick(int n, int p, int r);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (p + k) % n;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; midx[d] = 0; mnone[d] = 0; mmul[d] = 0;
      mpc[d] = 0; mm[d] = 0; mptr[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int r, pc, acc;
      r   = int'(req) & ((1 << nsz[d]) - 1);
      pc  = $countones(r);
      acc = (in_valid && (mv[d] == 0 || out_ready)) ? 1 : 0;
      if (multi_clr) mm[d] = 0;
      else if (acc == 1 && pc >= 2 && mm[d] < mmax[d]) mm[d]++;
      if (acc == 1) begin
        mv[d]    = 1;
        midx[d]  = pick(nsz[d], mptr[d], r);
        mnone[d] = (r == 0) ? 1 : 0;
        mmul[d]  = (pc >= 2) ? 1 : 0;
        mpc[d]   = pc;
        if (RR && r != 0) mptr[d] = (midx[d] + 1) % nsz[d];
      end else if (out_ready) begin
        mv[d] = 0;
      end
    end
  endtask

  task automatic cmp_one(string nm, int d, int v, int rdy, int idx, int none,
                         int mul, int cnt, int mc);
    chk({nm, ".out_valid"}, v, mv[d]);
    chk({nm, ".in_ready"}, rdy, (mv[d] == 0 || out_ready) ? 1 : 0);
    chk({nm, ".out_idx"}, idx, midx[d]);
    chk({nm, ".out_none"}, none, mnone[d]);
    chk({nm, ".out_multi"}, mul, mmul[d]);
    chk({nm, ".out_cnt"}, cnt, mpc[d]);
    chk({nm, ".multi_cnt"}, mc, mm[d]);
  endtask

  // Compare process: advance model on the rising edge, check on the falling edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      @(negedge clk);
      if (!rst_n) model_reset();
      cmp_one("A", 0, ia.out_valid, ia.in_ready, ia.out_idx, ia.out_none,
              ia.out_multi, ia.out_cnt, ia.multi_cnt);
      cmp_one("B", 1, ib.out_valid, ib.in_ready, ib.out_idx, ib.out_none,
              ib.out_multi, ib.out_cnt, ib.multi_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq[8] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
  int         erx[8] = '{0, 1, 0, 2, 3, 4, 0, 0};
  int         enone[8] = '{0, 0, 1, 0, 0, 0, 1, 0};

  // Directed then random stimulus with literal spot checks
  initial begin
    repeat (3) step();
    chk("rst.in_ready", ia.in_ready, 1);
    chk("rst.out_valid", ia.out_valid, 0);
    chk("rst.multi_cnt", ia.multi_cnt, 0);
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req = 8'(1 << i);
      step();
      chk("onehot.idx", ia.out_idx, i);
      chk("onehot.multi", ia.out_multi, 0);
    end
    chk("onehot.multi_cnt", ia.multi_cnt, 0);

    req = 8'h00;
    step();
    chk("zero.none", ia.out_none, 1);
    chk("zero.idx", ia.out_idx, 0);
    chk("zero.cnt", ia.out_cnt, 0);
    chk("zero.valid", ia.out_valid, 1);

    req = 8'hA4;
    step();
    chk("a4.idx", ia.out_idx, 2);
    chk("a4.multi", ia.out_multi, 1);
    chk("a4.cnt", ia.out_cnt, 3);
    chk("a4.multi_cnt", ia.multi_cnt, 1);

    req = 8'h08;
    step();
    out_ready = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.in_ready", ia.in_ready, 0);
      chk("stall.idx", ia.out_idx, 3);
      chk("stall.valid", ia.out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    chk("release.idx", ia.out_idx, 4);
    req = 8'h20;
    step();
    chk("nobubble.idx", ia.out_idx, 5);

    req = 8'h03;
    repeat (20) step();
    chk("sat.multi_cnt", ia.multi_cnt, 15);
    multi_clr = 1'b1;
    req = 8'h06;
    step();
    multi_clr = 1'b0;
    chk("clr.A", ia.multi_cnt, 0);
    chk("clr.B", ib.multi_cnt, 0);

    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req = seq[k];
      step();
      chk("rr.idx", ib.out_idx, RR ? erx[k] : 0);
      chk("rr.none", ib.out_none, enone[k]);
    end

    out_ready = 1'b0;
    req = 8'hFE;
    step();
    step();
    chk("hold.valid", ia.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.A.valid", ia.out_valid, 0);
    chk("midrst.B.valid", ib.out_valid, 0);
    chk("midrst.in_ready", ia.in_ready, 1);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    chk("stale.valid", ib.out_valid, 0);
    in_valid = 1'b1;
    req = 8'h1F;
    step();
    in_valid = 1'b0;
    chk("ptr0.idx", ib.out_idx, 0);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      multi_clr = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      step();
    end
    in_valid  = 1'b0;
    multi_clr = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
